cf_tmr32_icap: RTL and testbench

CF_TMR32_ICAP -- requirements
Module: cf_tmr32_icap

---
 rtl/cf_tmr32_pkg.sv | 28 ++
 rtl/cf_tmr32_icap_flt.sv | 60 ++++++
 rtl/cf_tmr32_icap.sv | 153 +++++++++++++++
 tb/tb_cf_tmr32_icap.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_tmr32_pkg.sv
// Shared definitions for the timer input-capture block.
//   - EDGE_* : encodings of the edge_sel control field
//   - icap_state_t : capture controller states
//   - edge_match() : decides whether a filtered edge is selected by edge_sel
package cf_tmr32_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_DONE  = 2'b10
    } icap_state_t;

    function automatic logic edge_match(input logic [1:0] sel,
                                        input logic       rise,
                                        input logic       fall);
        logic w_rise_ok;
        logic w_fall_ok;
        w_rise_ok = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
        w_fall_ok = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
        return (rise && w_rise_ok) || (fall && w_fall_ok);
    endfunction

endpackage

// File: rtl/cf_tmr32_icap_flt.sv
// Two-flop synchroniser plus run-length glitch filter for the capture pin.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_hold       : 1 = filter bypassed (filtered level tracks the synchronised
//                  pin, run counter held at 0, no edge pulses)
//   i_pin        : asynchronous capture pin
//   i_flt_len    : filter length; a new level must persist flt_len+1 cycles
//   o_filt       : filtered level
//   o_rise/o_fall: combinational pulses, high in the cycle whose closing clock
//                  edge toggles o_filt, so the caller can store at that edge
module cf_tmr32_icap_flt #(
    parameter int FLT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hold,
    input  logic             i_pin,
    input  logic [FLT_W-1:0] i_flt_len,
    output logic             o_filt,
    output logic             o_rise,
    output logic             o_fall
);

    logic             r_sync1;
    logic             r_sync_q;
    logic             r_filt_q;
    logic [FLT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_toggle;

    // r_cnt counts earlier disagreeing cycles, so the current one is the
    // (r_cnt+1)-th; it never passes i_flt_len while the length is stable.
    assign w_diff   = r_sync_q ^ r_filt_q;
    assign w_toggle = !i_hold && w_diff && (r_cnt == i_flt_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync_q <= 1'b0;
            r_filt_q <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_pin;
            r_sync_q <= r_sync1;
            if (i_hold || w_toggle) begin
                r_filt_q <= r_sync_q;
                r_cnt    <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt_q;
    assign o_rise = w_toggle && r_sync_q;
    assign o_fall = w_toggle && !r_sync_q;

endmodule

// File: rtl/cf_tmr32_icap.sv
// Timer input-capture unit: filtered pin edges selected by edge_sel store
// {polarity, tmr} into a small FIFO read by software.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : block enable (0 = idle, FIFO flushed)
//   icap_in           : asynchronous capture pin
//   tmr               : free-running timer value
//   edge_sel          : 00 none, 01 rising, 10 falling, 11 both
//   flt_len           : glitch-filter length
//   oneshot           : stop after the first stored capture
//   rd                : pop the head entry
//   ovf_clr           : clear the sticky overflow flag
//   cap_data, cap_pol : head-entry timestamp and polarity (1 = rising)
//   cap_valid         : FIFO non-empty
//   level             : FIFO occupancy, 0..DEPTH
//   cap_flag          : one-cycle pulse after each stored capture
//   ovf_flag          : sticky overflow, set when a capture is dropped
module cf_tmr32_icap
    import cf_tmr32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FLT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     icap_in,
    input  logic [31:0]              tmr,
    input  logic [1:0]               edge_sel,
    input  logic [FLT_W-1:0]         flt_len,
    input  logic                     oneshot,
    input  logic                     rd,
    input  logic                     ovf_clr,
    output logic [31:0]              cap_data,
    output logic                     cap_pol,
    output logic                     cap_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     cap_flag,
    output logic                     ovf_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    icap_state_t   r_state;
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic [32:0]   r_mem [DEPTH];
    logic          r_cap_flag;
    logic          r_ovf_flag;

    logic          w_idle;
    logic          w_filt;
    logic          w_rise;
    logic          w_fall;
    logic          w_pol;
    logic [LW-1:0] w_level;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_req;
    logic          w_push;
    logic          w_ovf;
    logic [32:0]   w_head;

    assign w_idle = (r_state == ST_IDLE);

    cf_tmr32_icap_flt #(
        .FLT_W (FLT_W)
    ) u_flt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_hold    (w_idle),
        .i_pin     (icap_in),
        .i_flt_len (flt_len),
        .o_filt    (w_filt),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // The filtered level is still the pre-edge value while an event is
    // flagged, so the new polarity is its complement.
    assign w_pol = ~w_filt;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LW'(DEPTH));
    assign w_pop   = rd && !w_empty && !w_idle;
    assign w_req   = en && (r_state == ST_ARMED) && edge_match(edge_sel, w_rise, w_fall);
    // A full FIFO still accepts a capture when the head leaves at the same edge.
    assign w_push  = w_req && (!w_full || w_pop);
    assign w_ovf   = w_req && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (!en) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_ARMED;
                ST_ARMED: if (w_push && oneshot) r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_idle) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {w_pol, tmr};
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A dropped capture in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_flag <= 1'b0;
            r_ovf_flag <= 1'b0;
        end else begin
            r_cap_flag <= w_push;
            if (w_ovf) begin
                r_ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_flag <= 1'b0;
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign cap_data  = w_head[31:0];
    assign cap_pol   = w_head[32];
    assign cap_valid = !w_empty;
    assign level     = w_level;
    assign cap_flag  = r_cap_flag;
    assign ovf_flag  = r_ovf_flag;

endmodule

// File: tb/tb_cf_tmr32_icap.sv
// Self-checking bench for cf_tmr32_icap: directed scenarios plus a long
// randomized run, all compared against a cycle-level behavioural model.
module tb_cf_tmr32_icap;

    localparam int DEPTH = 4;
    localparam int FLT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             icap_in = 1'b0;
    logic [31:0]      tmr = 32'd0;
    logic [1:0]       edge_sel = 2'b00;
    logic [FLT_W-1:0] flt_len = '0;
    logic             oneshot = 1'b0;
    logic             rd = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [31:0]      cap_data;
    logic             cap_pol;
    logic             cap_valid;
    logic [LW-1:0]    level;
    logic             cap_flag;
    logic             ovf_flag;

    int total = 0;
    int bad   = 0;

    cf_tmr32_icap #(.DEPTH(DEPTH), .FLT_W(FLT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .icap_in(icap_in), .tmr(tmr),
        .edge_sel(edge_sel), .flt_len(flt_len), .oneshot(oneshot), .rd(rd),
        .ovf_clr(ovf_clr), .cap_data(cap_data), .cap_pol(cap_pol),
        .cap_valid(cap_valid), .level(level), .cap_flag(cap_flag),
        .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    // Behavioural model: pin delayed two cycles, a run length of disagreeing
    // cycles, an enable history, and a queue of stored entries.
    bit          m_s1, m_s2, m_filt;
    int          m_run;
    bit          m_active, m_done, m_flag, m_ovf;
    logic [32:0] m_q[$];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_filt = 0; m_run = 0;
        m_active = 0; m_done = 0; m_flag = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit diff, tog, rise, fall, sel_r, sel_f, want, pop, full, push;
        diff  = (m_s2 != m_filt);
        tog   = m_active && diff && ((m_run + 1) == (int'(flt_len) + 1));
        rise  = tog && m_s2;
        fall  = tog && !m_s2;
        sel_r = (edge_sel == 2'b01) || (edge_sel == 2'b11);
        sel_f = (edge_sel == 2'b10) || (edge_sel == 2'b11);
        want  = en && m_active && !m_done && ((rise && sel_r) || (fall && sel_f));
        pop   = rd && m_active && (m_q.size() > 0);
        full  = (m_q.size() == DEPTH);
        push  = want && (!full || pop);
        if (!m_active) m_q.delete();
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({rise, tmr});
        m_flag = push;
        if (want && full && !pop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (!en) m_done = 0;
        else if (push && oneshot) m_done = 1;
        if (!m_active || tog) begin
            m_filt = m_s2;
            m_run  = 0;
        end else if (diff) begin
            m_run++;
        end else begin
            m_run = 0;
        end
        m_active = en;
        m_s2 = m_s1;
        m_s1 = icap_in;
    endtask

    // One clock: model advances on the pre-edge inputs, outputs are then
    // sampled 1 time unit after the edge; the timer keeps counting.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        tmr = tmr + 32'd1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (cap_data !== 32'd0) begin bad++; $display("FAIL rst_data: got %0h want 0", cap_data); end
        total++; if (cap_pol !== 1'b0) begin bad++; $display("FAIL rst_pol: got %0b want 0", cap_pol); end
        total++; if (cap_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", cap_valid); end
        total++; if (level !== '0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++; if ({cap_flag, ovf_flag} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {cap_flag, ovf_flag}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        total++; if (level !== '0) begin bad++; $display("FAIL rst_idle_level: got %0d want 0", level); end
    endtask

    task automatic test_basic();
        logic [31:0] t0;
        logic [32:0] got;
        logic [LW-1:0] lvl;
        logic flg;
        int hit;
        en = 1; edge_sel = 2'b01; flt_len = '0; oneshot = 0; icap_in = 0;
        tmr = 32'd100;
        repeat (3) tick();
        t0 = tmr; icap_in = 1; hit = 0; got = '0; lvl = '0; flg = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (hit == 0 && cap_valid) begin hit = k; got = {cap_pol, cap_data}; lvl = level; flg = cap_flag; end
        end
        total++; if (hit !== 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", hit); end
        total++; if (got !== {1'b1, t0 + 32'd2}) begin bad++; $display("FAIL basic_entry: got %h want %h", got, {1'b1, t0 + 32'd2}); end
        total++; if (lvl !== LW'(1)) begin bad++; $display("FAIL basic_level: got %0d want 1", lvl); end
        total++; if (flg !== 1'b1) begin bad++; $display("FAIL basic_flag: got %0b want 1", flg); end
        total++; if (cap_flag !== 1'b0) begin bad++; $display("FAIL basic_flag_once: got %0b want 0", cap_flag); end
        rd = 1; tick(); rd = 0;
        total++; if ({cap_valid, level} !== {1'b0, LW'(0)}) begin bad++; $display("FAIL basic_pop: got valid=%0b level=%0d want 0/0", cap_valid, level); end
        icap_in = 0; repeat (5) tick();
        total++; if (level !== '0) begin bad++; $display("FAIL basic_fall_ignored: got %0d want 0", level); end
    endtask

    task automatic test_filter();
        logic [31:0] t0;
        logic [32:0] got;
        int hit, seen;
        flt_len = FLT_W'(3);
        icap_in = 1; repeat (3) tick(); icap_in = 0;
        seen = 0;
        repeat (10) begin tick(); if (cap_flag) seen++; end
        total++; if (seen !== 0 || level !== '0) begin bad++; $display("FAIL flt_glitch: got flags=%0d level=%0d want 0/0", seen, level); end
        t0 = tmr; icap_in = 1; hit = 0; got = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (hit == 0 && cap_valid) begin hit = k; got = {cap_pol, cap_data}; end
        end
        total++; if (hit !== 6) begin bad++; $display("FAIL flt_latency: got %0d want 6", hit); end
        total++; if (got !== {1'b1, t0 + 32'd5}) begin bad++; $display("FAIL flt_entry: got %h want %h", got, {1'b1, t0 + 32'd5}); end
        icap_in = 0; repeat (8) tick();
        rd = 1; tick(); rd = 0;
        total++; if (level !== '0) begin bad++; $display("FAIL flt_drain: got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        logic [32:0] exp_e[5];
        edge_sel = 2'b11; flt_len = '0;
        ovf_clr = 1; tick(); ovf_clr = 0;
        for (int i = 0; i < 5; i++) begin
            icap_in = ~icap_in;
            exp_e[i] = {icap_in, tmr + 32'd2};
            repeat (4) tick();
        end
        total++; if (level !== LW'(4)) begin bad++; $display("FAIL ovf_level: got %0d want 4", level); end
        total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", ovf_flag); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({cap_pol, cap_data} !== exp_e[i]) begin bad++; $display("FAIL ovf_order%0d: got %h want %h", i, {cap_pol, cap_data}, exp_e[i]); end
            rd = 1; tick(); rd = 0;
        end
        total++; if ({cap_valid, ovf_flag} !== 2'b01) begin bad++; $display("FAIL ovf_sticky: got valid/ovf=%b want 01", {cap_valid, ovf_flag}); end
        ovf_clr = 1; tick(); ovf_clr = 0;
        total++; if (ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0b want 0", ovf_flag); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_e[5];
        for (int i = 0; i < 4; i++) begin
            icap_in = ~icap_in;
            exp_e[i] = {icap_in, tmr + 32'd2};
            repeat (4) tick();
        end
        icap_in = ~icap_in;
        exp_e[4] = {icap_in, tmr + 32'd2};
        repeat (2) tick();
        rd = 1; tick(); rd = 0;
        total++; if (level !== LW'(4)) begin bad++; $display("FAIL b2b_level: got %0d want 4", level); end
        total++; if ({cap_flag, ovf_flag} !== 2'b10) begin bad++; $display("FAIL b2b_flags: got %b want 10", {cap_flag, ovf_flag}); end
        for (int i = 1; i < 5; i++) begin
            total++; if ({cap_pol, cap_data} !== exp_e[i]) begin bad++; $display("FAIL b2b_order%0d: got %h want %h", i, {cap_pol, cap_data}, exp_e[i]); end
            rd = 1; tick(); rd = 0;
        end
        for (int i = 0; i < 4; i++) begin
            icap_in = ~icap_in;
            repeat (4) tick();
        end
        icap_in = ~icap_in;
        repeat (2) tick();
        ovf_clr = 1; tick(); ovf_clr = 0;
        total++; if ({ovf_flag, cap_flag, level} !== {2'b10, LW'(4)}) begin bad++; $display("FAIL ovf_wins: got ovf=%0b flag=%0b level=%0d want 1/0/4", ovf_flag, cap_flag, level); end
        ovf_clr = 1; tick(); ovf_clr = 0;
        en = 0; repeat (2) tick();
        total++; if ({ovf_flag, level} !== {1'b0, LW'(0)}) begin bad++; $display("FAIL idle_flush: got ovf=%0b level=%0d want 0/0", ovf_flag, level); end
    endtask

    task automatic test_oneshot();
        icap_in = 0; repeat (4) tick();
        edge_sel = 2'b01; oneshot = 1; en = 1; repeat (2) tick();
        repeat (2) begin
            icap_in = 1; repeat (4) tick();
            icap_in = 0; repeat (4) tick();
        end
        total++; if ({level, cap_pol} !== {LW'(1), 1'b1}) begin bad++; $display("FAIL oneshot_one: got level=%0d pol=%0b want 1/1", level, cap_pol); end
        en = 0; repeat (2) tick();
        total++; if (level !== '0) begin bad++; $display("FAIL oneshot_flush: got %0d want 0", level); end
        en = 1; repeat (2) tick();
        icap_in = 1; repeat (4) tick();
        total++; if ({level, cap_pol} !== {LW'(1), 1'b1}) begin bad++; $display("FAIL oneshot_rearm: got level=%0d pol=%0b want 1/1", level, cap_pol); end
        oneshot = 0; en = 0; icap_in = 0; repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        logic [32:0] got;
        int hit, seen;
        edge_sel = 2'b11; flt_len = '0; en = 1; repeat (2) tick();
        icap_in = 1; repeat (4) tick();
        icap_in = 0; repeat (4) tick();
        total++; if (level !== LW'(2)) begin bad++; $display("FAIL rmid_pre: got %0d want 2", level); end
        flt_len = FLT_W'(3);
        icap_in = 1; repeat (3) tick();
        rst_n = 0; #1;
        total++; if ({cap_valid, level, cap_flag, ovf_flag} !== '0) begin bad++; $display("FAIL rmid_ctrl: got valid=%0b level=%0d flag=%0b ovf=%0b want 0", cap_valid, level, cap_flag, ovf_flag); end
        total++; if ({cap_pol, cap_data} !== 33'd0) begin bad++; $display("FAIL rmid_data: got %h want 0", {cap_pol, cap_data}); end
        model_reset();
        en = 0; icap_in = 0;
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) icap_in = ~icap_in;
            tick();
            if (cap_flag || cap_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_cap: got %0d captures want 0", seen); end
        icap_in = 0; repeat (6) tick();
        en = 1; repeat (2) tick();
        icap_in = 1; hit = 0; got = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (hit == 0 && cap_valid) begin hit = k; got = {cap_pol, cap_data}; end
        end
        total++; if (hit !== 6 || got[32] !== 1'b1) begin bad++; $display("FAIL rmid_recap: got latency=%0d pol=%0b want 6/1", hit, got[32]); end
        rd = 1; tick(); rd = 0;
    endtask

    task automatic test_random();
        int run_left;
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                icap_in  = ~icap_in;
                run_left = $urandom_range(1, 7);
            end
            run_left--;
            rd      = ($urandom_range(0, 3) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) oneshot = ~oneshot;
            if (en && $urandom_range(0, 99) == 0) en = 0;
            else if (!en && $urandom_range(0, 7) == 0) en = 1;
            else if (!en && !m_active) flt_len = FLT_W'($urandom_range(0, 3));
            tick();
            total++; if (level !== LW'(m_q.size())) begin bad++; $display("FAIL rnd_level c=%0d: got %0d want %0d", c, level, m_q.size()); end
            total++; if (cap_valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid c=%0d: got %0b want %0b", c, cap_valid, m_q.size() > 0); end
            total++; if (cap_flag !== m_flag) begin bad++; $display("FAIL rnd_flag c=%0d: got %0b want %0b", c, cap_flag, m_flag); end
            total++; if (ovf_flag !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d: got %0b want %0b", c, ovf_flag, m_ovf); end
            if (m_q.size() > 0) begin
                total++; if ({cap_pol, cap_data} !== m_q[0]) begin bad++; $display("FAIL rnd_head c=%0d: got %h want %h", c, {cap_pol, cap_data}, m_q[0]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_back_to_back();
        test_oneshot();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
